// File: rtl/seq_table_ctrl.sv
// seq_table_ctrl: programmable table sequencer emitting one entry per beat on a valid/ready stream
module seq_table_ctrl #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int STEP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]          cfg_wdata,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic                       start,
  input  logic [STEP_W-1:0]          run_steps,
  input  logic                       abort,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH)-1:0]   out_index,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state;
  logic [DATA_W-1:0] tbl [DEPTH];
  logic [AW:0] len_q;
  logic [STEP_W-1:0] rem_q;
  logic hs, len_ok;
  logic [AW-1:0] nidx;
  function automatic logic [DATA_W-1:0] dflt(input int i);
    case (i)
      0: dflt = DATA_W'(13);
      1: dflt = DATA_W'(2);
      2: dflt = DATA_W'(15);
      3: dflt = DATA_W'(11);
      4: dflt = DATA_W'(7);
      5: dflt = DATA_W'(9);
      6: dflt = DATA_W'(4);
      7: dflt = DATA_W'(8);
      8: dflt = DATA_W'(14);
      9: dflt = DATA_W'(1);
      10: dflt = DATA_W'(10);
      default: dflt = '0;
    endcase
  endfunction
  assign hs = out_valid & out_ready;
  assign len_ok = (cfg_len != '0) && (cfg_len <= (AW+1)'(DEPTH));
  assign nidx = (({1'b0, out_index} + (AW+1)'(1)) == len_q) ? '0 : out_index + AW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_data <= '0;
      out_index <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      len_q <= '0;
      rem_q <= '0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= dflt(i);
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) tbl[cfg_addr] <= cfg_wdata;
          if (start && len_ok) begin
            state <= RUN;
            len_q <= cfg_len;
            rem_q <= run_steps;
            out_index <= '0;
            // a same-cycle write to entry 0 must be visible in the first beat
            out_data <= (cfg_we && cfg_addr == '0) ? cfg_wdata : tbl[0];
            out_valid <= 1'b1;
            busy <= 1'b1;
          end else if (start) err <= 1'b1;
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            out_valid <= 1'b0;
            busy <= 1'b0;
          end else if (hs) begin
            if (rem_q != '0) rem_q <= rem_q - STEP_W'(1);
            if (rem_q == STEP_W'(1)) begin
              state <= FIN;
              out_valid <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              out_index <= nidx;
              out_data <= tbl[nidx];
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_table_ctrl.sv
// tb_seq_table_ctrl: directed self-checking bench for seq_table_ctrl
module tb_seq_table_ctrl;
  logic clk = 0, rst = 1, cfg_we = 0, start = 0, abort = 0, out_ready = 0;
  logic [3:0] cfg_addr = 0;
  logic [7:0] cfg_wdata = 0;
  logic [4:0] cfg_len = 0;
  logic [15:0] run_steps = 0;
  logic out_valid, busy, done, err;
  logic [7:0] out_data;
  logic [3:0] out_index;
  int n = 0, fails = 0;
  int b;
  byte unsigned dflt [11] = '{13, 2, 15, 11, 7, 9, 4, 8, 14, 1, 10};
  byte unsigned prog [3] = '{8'hAA, 8'h55, 8'h01};

  always #5 clk = ~clk;

  seq_table_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_len(cfg_len), .start(start), .run_steps(run_steps), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int len, input int steps);
    cfg_len = 5'(len);
    run_steps = 16'(steps);
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic check_default_seq(input int beats);
    for (int i = 0; i < beats; i++) begin
      chk("beat_data", out_data, dflt[i % 11]);
      chk("beat_idx", out_index, i % 11);
      chk("beat_valid", out_valid, 1);
      chk("beat_busy", busy, 1);
      chk("beat_done", done, 0);
      tick;
    end
    chk("fin_done", done, 1);
    chk("fin_valid", out_valid, 0);
    chk("fin_busy", busy, 0);
    tick;
    chk("idle_done", done, 0);
  endtask

  initial begin
    tick;
    tick;
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    out_ready = 1;
    start_run(11, 11);
    check_default_seq(11);
    start_run(11, 14);
    check_default_seq(14);
    cfg_we = 1;
    for (int i = 0; i < 3; i++) begin
      cfg_addr = 4'(i);
      cfg_wdata = prog[i];
      tick;
    end
    cfg_we = 0;
    out_ready = 0;
    start_run(3, 0);
    b = 0;
    for (int k = 0; k < 12; k++) begin
      out_ready = (k % 2 == 0);
      chk("cont_data", out_data, prog[b % 3]);
      chk("cont_idx", out_index, b % 3);
      chk("cont_valid", out_valid, 1);
      chk("cont_done", done, 0);
      tick;
      if (out_ready) b++;
    end
    out_ready = 0;
    abort = 1;
    tick;
    abort = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick;
    chk("abort_done2", done, 0);
    out_ready = 1;
    start_run(3, 1);
    abort = 1;
    tick;
    abort = 0;
    chk("abort_last_done", done, 0);
    chk("abort_last_valid", out_valid, 0);
    tick;
    chk("abort_last_done2", done, 0);
    start_run(0, 5);
    chk("len0_err", err, 1);
    chk("len0_valid", out_valid, 0);
    chk("len0_busy", busy, 0);
    tick;
    chk("len0_err_clr", err, 0);
    start_run(17, 5);
    chk("len17_err", err, 1);
    chk("len17_valid", out_valid, 0);
    tick;
    chk("len17_err_clr", err, 0);
    chk("len17_busy", busy, 0);
    start_run(16, 1);
    chk("len16_ok_err", err, 0);
    chk("len16_valid", out_valid, 1);
    tick;
    chk("len16_done", done, 1);
    tick;
    out_ready = 0;
    start_run(3, 0);
    chk("frz_data0", out_data, 8'hAA);
    cfg_we = 1;
    cfg_addr = 0;
    cfg_wdata = 8'h77;
    start = 1;
    tick;
    cfg_we = 0;
    start = 0;
    chk("frz_data1", out_data, 8'hAA);
    chk("frz_idx", out_index, 0);
    chk("frz_busy", busy, 1);
    abort = 1;
    tick;
    abort = 0;
    out_ready = 1;
    start_run(3, 1);
    chk("frz_after", out_data, 8'hAA);
    tick;
    chk("frz_done", done, 1);
    tick;
    cfg_we = 1;
    cfg_addr = 0;
    cfg_wdata = 8'h5A;
    start_run(3, 1);
    cfg_we = 0;
    chk("wr_start_data", out_data, 8'h5A);
    tick;
    tick;
    start_run(3, 0);
    tick;
    tick;
    chk("mid_idx", out_index, 2);
    rst = 1;
    tick;
    rst = 0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_idx", out_index, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    start_run(11, 11);
    check_default_seq(11);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/seq_table_ctrl.md
Name: seq_table_ctrl

Overview:
- Programmable sequence scheduler for the 8-bit count datapath.
- Holds a small value table, runs through it in order with wrap-around, and emits one value per beat on a valid/ready stream.
- Runs for a commanded number of beats, or continuously, with abort.
- A config port reprograms the table between runs; after reset the table holds the team's standard 11-entry count sequence.

Parameters:
- DEPTH, 16, number of table entries (power of 2, at least 11)
- DATA_W, 8, width of each table entry and of out_data
- STEP_W, 16, width of the beat-count command

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  log2(DEPTH)  table write address
- cfg_wdata  in  DATA_W  table write data
- cfg_len  in  log2(DEPTH)+1  active entry count, sampled on start
- start  in  1  begin a run (level sampled when IDLE)
- run_steps  in  STEP_W  beats to emit, sampled on start; 0 = continuous
- abort  in  1  terminate the current run
- out_valid  out  1  out_data holds a valid beat
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  current table value
- out_index  out  log2(DEPTH)  table index of out_data
- busy  out  1  run in progress (RUN state)
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse on rejected start

Behaviour:
Decided interface facts: one clock, clk; reset rst is synchronous and active-high.

Reset values:
- Outputs: out_valid=0, out_data=0, out_index=0, busy=0, done=0, err=0; state=IDLE.
- Table entries 0..10 = 13,2,15,11,7,9,4,8,14,1,10; entries 11..DEPTH-1 = 0.
- rst mid-run aborts immediately and restores the table defaults. No done pulse.

States: IDLE, RUN, FIN.

IDLE:
- cfg_we writes table[cfg_addr] <= cfg_wdata at the next edge.
- start with 1 <= cfg_len <= DEPTH: latch len_q=cfg_len and rem_q=run_steps; idx=0; go to RUN.
- Registered latency of 1 cycle: out_valid=1, out_data=table[0], out_index=0 in the cycle after start.
- start with cfg_len=0 or cfg_len>DEPTH: err=1 for one cycle; stay IDLE.
- start and cfg_we in the same cycle: the write happens. The first beat sees the new value only if it targets entry 0.

RUN:
- busy=1 and out_valid=1 continuously.
- out_data and out_index stay stable until a handshake (out_valid & out_ready).
- On handshake:
  - idx advances to idx+1; wraps to 0 after len_q-1.
  - If rem_q != 0, rem_q decrements.
  - If rem_q was 1, go to FIN: out_valid=0 next cycle.
  - Otherwise the next entry is presented next cycle, giving full throughput with out_ready held high.
- Continuous mode (rem_q latched 0) never reaches FIN by count.
- abort: next cycle is IDLE with out_valid=0, busy=0, no done pulse.
  - A handshake in the same cycle as abort counts as delivered.
  - abort takes priority over a simultaneous final beat: no done pulse.
- cfg_we and start are ignored while in RUN or FIN. The table is frozen for the whole run.

FIN:
- Lasts one cycle: done=1, busy=0, out_valid=0.
- Next state is IDLE.
- start asserted in FIN is ignored; it must be reasserted in IDLE.

Other rules:
- abort in IDLE or FIN has no effect.
- out_data and out_index hold their last values when out_valid=0.
- Index and length arithmetic is unsigned.
- rem_q saturates at 0 and never underflows.

Test Plan:
- After reset: cfg_len=11, run_steps=11, start, out_ready=1 -> beats 13,2,15,11,7,9,4,8,14,1,10 on consecutive cycles, first beat one cycle after start; done pulses once the cycle after the last beat.
- Same setup with run_steps=14 -> 13,2,15,11,7,9,4,8,14,1,10,13,2,15 (index wraps at 10 to 0), then done.
- Write entries 0..2 = 0xAA,0x55,0x01; cfg_len=3, run_steps=0, out_ready toggled 1/0 -> AA,55,01,AA,... repeating; each value held stable while out_ready=0; no done; abort -> out_valid=0 next cycle, no done.
- cfg_len=0 and cfg_len=17 -> err pulses one cycle each, state stays IDLE, out_valid stays 0.
- During RUN: cfg_we to entry 0 and a second start -> both ignored; a following run still emits the original entry-0 value.
- rst asserted mid-run after reprogramming -> next cycle all outputs 0, state IDLE; a new 11-beat run emits the default 13,2,15,... sequence.
